// File: rtl/hbconsole_defs.sv
// Shared constants for the hexbus/console UART link: newline, FSM encodings,
// and the position of the channel tag bit within a UART byte.
package hbconsole_defs;

  localparam logic [6:0] NEWLINE   = 7'h0a;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_HB_PKT = 1'b1;

  localparam int   TAG_BIT = 7;
  localparam logic TAG_HB  = 1'b1;
  localparam logic TAG_CON = 1'b0;

  function automatic logic [7:0] tag_char(input logic tag, input logic [6:0] ch);
    logic [7:0] b;
    b          = {1'b0, ch};
    b[TAG_BIT] = tag;
    return b;
  endfunction

endpackage

// File: rtl/hbconsole_link.sv
// Shares one UART between a 7-bit console and a 7-bit hexbus channel: the top
// bit of every byte tags the channel, and a hexbus packet owns tx until newline.
module hbconsole_link
  import hbconsole_defs::*;
#(
  parameter int LGIDLE = 10
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_byte,
  output logic       o_con_rx_stb,
  output logic [6:0] o_con_rx_data,
  output logic       o_hb_rx_stb,
  output logic [6:0] o_hb_rx_data,
  input  logic       i_con_tx_stb,
  input  logic [6:0] i_con_tx_data,
  output logic       o_con_tx_busy,
  input  logic       i_hb_tx_stb,
  input  logic [6:0] i_hb_tx_data,
  output logic       o_hb_tx_busy,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_busy
);

  localparam logic [LGIDLE-1:0] CNT_ONE = {{(LGIDLE-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic              last_hb;
  logic [LGIDLE-1:0] idle_cnt;

  logic load;
  logic sel_hb;
  logic hb_accept;
  logic con_accept;
  logic hb_newline;
  logic idle_done;

  // Arbitration: the output register can take a byte when empty or draining.
  always_comb begin
    load       = i_reset_n && (!o_tx_stb || !i_tx_busy);
    sel_hb     = (state == ST_HB_PKT) || (i_hb_tx_stb && !(last_hb && i_con_tx_stb));
    hb_accept  = load && sel_hb && i_hb_tx_stb;
    con_accept = load && !sel_hb && i_con_tx_stb;
    hb_newline = (i_hb_tx_data == NEWLINE);
    idle_done  = &idle_cnt;
  end

  assign o_hb_tx_busy  = !(load && sel_hb);
  assign o_con_tx_busy = !(load && !sel_hb);

  // Rx demux stage
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_con_rx_stb  <= 1'b0;
      o_hb_rx_stb   <= 1'b0;
      o_con_rx_data <= 7'h00;
      o_hb_rx_data  <= 7'h00;
    end else begin
      o_con_rx_stb <= i_rx_stb && (i_rx_byte[TAG_BIT] == TAG_CON);
      o_hb_rx_stb  <= i_rx_stb && (i_rx_byte[TAG_BIT] == TAG_HB);
      if (i_rx_stb && (i_rx_byte[TAG_BIT] == TAG_CON))
        o_con_rx_data <= i_rx_byte[6:0];
      if (i_rx_stb && (i_rx_byte[TAG_BIT] == TAG_HB))
        o_hb_rx_data <= i_rx_byte[6:0];
    end
  end

  // Tx output stage
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_tx_stb  <= 1'b0;
      o_tx_byte <= 8'h00;
    end else if (hb_accept) begin
      o_tx_stb  <= 1'b1;
      o_tx_byte <= tag_char(TAG_HB, i_hb_tx_data);
    end else if (con_accept) begin
      o_tx_stb  <= 1'b1;
      o_tx_byte <= tag_char(TAG_CON, i_con_tx_data);
    end else if (!i_tx_busy) begin
      o_tx_stb  <= 1'b0;
    end
  end

  // Packet ownership: a stalled hexbus packet is abandoned after the idle timeout
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      last_hb  <= 1'b0;
      idle_cnt <= '0;
    end else if (state == ST_IDLE) begin
      idle_cnt <= '0;
      if (hb_accept) begin
        if (hb_newline)
          last_hb <= 1'b1;
        else
          state   <= ST_HB_PKT;
      end else if (con_accept) begin
        last_hb <= 1'b0;
      end
    end else begin
      if (hb_accept && hb_newline) begin
        state    <= ST_IDLE;
        last_hb  <= 1'b1;
        idle_cnt <= '0;
      end else if (i_hb_tx_stb) begin
        idle_cnt <= '0;
      end else if (idle_done) begin
        state    <= ST_IDLE;
        last_hb  <= 1'b1;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hbconsole_link.sv
// Bench for hbconsole_link: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model of the link.
module tb_hbconsole_link;

  localparam int LG = 4;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_rx_stb;
  logic [7:0] i_rx_byte;
  logic       o_con_rx_stb;
  logic [6:0] o_con_rx_data;
  logic       o_hb_rx_stb;
  logic [6:0] o_hb_rx_data;
  logic       i_con_tx_stb;
  logic [6:0] i_con_tx_data;
  logic       o_con_tx_busy;
  logic       i_hb_tx_stb;
  logic [6:0] i_hb_tx_data;
  logic       o_hb_tx_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_byte;
  logic       i_tx_busy;

  always #5 i_clk = ~i_clk;

  hbconsole_link #(.LGIDLE(LG)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_rx_stb     (i_rx_stb),
    .i_rx_byte    (i_rx_byte),
    .o_con_rx_stb (o_con_rx_stb),
    .o_con_rx_data(o_con_rx_data),
    .o_hb_rx_stb  (o_hb_rx_stb),
    .o_hb_rx_data (o_hb_rx_data),
    .i_con_tx_stb (i_con_tx_stb),
    .i_con_tx_data(i_con_tx_data),
    .o_con_tx_busy(o_con_tx_busy),
    .i_hb_tx_stb  (i_hb_tx_stb),
    .i_hb_tx_data (i_hb_tx_data),
    .o_hb_tx_busy (o_hb_tx_busy),
    .o_tx_stb     (o_tx_stb),
    .o_tx_byte    (o_tx_byte),
    .i_tx_busy    (i_tx_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: packet ownership, fairness flag, quiet-cycle count
  bit         m_pkt, m_last_hb;
  int         m_quiet;
  bit         m_tx_stb;
  logic [7:0] m_tx_byte;
  bit         m_crx, m_hrx;
  logic [6:0] m_crx_d, m_hrx_d;

  logic [6:0] hb_q[$];
  logic [6:0] con_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 0; m_last_hb = 0; m_quiet = 0;
    m_tx_stb = 0; m_tx_byte = 8'h00;
    m_crx = 0; m_hrx = 0; m_crx_d = 7'h00; m_hrx_d = 7'h00;
  endtask

  task automatic drive_sources();
    i_hb_tx_stb   = (hb_q.size() > 0);
    i_hb_tx_data  = 7'h00;
    if (hb_q.size() > 0) i_hb_tx_data = hb_q[0];
    i_con_tx_stb  = (con_q.size() > 0);
    i_con_tx_data = 7'h00;
    if (con_q.size() > 0) i_con_tx_data = con_q[0];
  endtask

  task automatic check_sent(input string tag);
    chk({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < sent_q.size()) chk(tag, 32'(sent_q[i]), 32'(exp_q[i]));
    sent_q.delete();
    exp_q.delete();
  endtask

  // One clock of traffic: busies checked at the falling edge, registers after the rise
  task automatic step(input bit rx_stb, input logic [7:0] rx_byte);
    bit can_load, hb_turn, hb_go, con_go, fresh;
    logic [6:0] hd, cd;
    i_rx_stb  = rx_stb;
    i_rx_byte = rx_byte;
    drive_sources();
    @(negedge i_clk);
    hd       = i_hb_tx_data;
    cd       = i_con_tx_data;
    fresh    = !o_tx_stb || !i_tx_busy;
    can_load = !m_tx_stb || !i_tx_busy;
    hb_turn  = m_pkt || (i_hb_tx_stb && !(m_last_hb && i_con_tx_stb));
    chk("hb_busy", 32'(o_hb_tx_busy), 32'(!(can_load && hb_turn)));
    chk("con_busy", 32'(o_con_tx_busy), 32'(!(can_load && !hb_turn)));
    hb_go  = can_load && hb_turn && i_hb_tx_stb;
    con_go = can_load && !hb_turn && i_con_tx_stb;
    if (hb_go) begin
      m_tx_stb = 1; m_tx_byte = {1'b1, hd}; void'(hb_q.pop_front());
    end else if (con_go) begin
      m_tx_stb = 1; m_tx_byte = {1'b0, cd}; void'(con_q.pop_front());
    end else if (!i_tx_busy) begin
      m_tx_stb = 0;
    end
    if (!m_pkt) begin
      if (hb_go) begin
        if (hd == 7'h0a) m_last_hb = 1;
        else begin m_pkt = 1; m_quiet = 0; end
      end else if (con_go) m_last_hb = 0;
    end else begin
      if (hb_go && hd == 7'h0a) begin m_pkt = 0; m_last_hb = 1; end
      else if (i_hb_tx_stb) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == (1 << LG)) begin m_pkt = 0; m_last_hb = 1; m_quiet = 0; end
      end
    end
    m_crx = rx_stb && !rx_byte[7];
    m_hrx = rx_stb && rx_byte[7];
    if (m_crx) m_crx_d = rx_byte[6:0];
    if (m_hrx) m_hrx_d = rx_byte[6:0];
    @(posedge i_clk);
    #1;
    chk("tx_stb", 32'(o_tx_stb), 32'(m_tx_stb));
    if (m_tx_stb) chk("tx_byte", 32'(o_tx_byte), 32'(m_tx_byte));
    chk("con_rx_stb", 32'(o_con_rx_stb), 32'(m_crx));
    chk("hb_rx_stb", 32'(o_hb_rx_stb), 32'(m_hrx));
    if (m_crx) chk("con_rx_data", 32'(o_con_rx_data), 32'(m_crx_d));
    if (m_hrx) chk("hb_rx_data", 32'(o_hb_rx_data), 32'(m_hrx_d));
    if (o_tx_stb && fresh) sent_q.push_back(o_tx_byte);
    i_rx_stb = 1'b0;
    drive_sources();
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_rx_stb = 1'b0; i_rx_byte = 8'h00; i_tx_busy = 1'b0;
    drive_sources();
    model_reset();

    // Reset state, including busy asserted while a request is present
    repeat (2) @(posedge i_clk);
    #1;
    i_hb_tx_stb = 1'b1; i_hb_tx_data = 7'h41;
    i_con_tx_stb = 1'b1; i_con_tx_data = 7'h42;
    #1;
    chk("rst_tx_stb", 32'(o_tx_stb), 0);
    chk("rst_tx_byte", 32'(o_tx_byte), 0);
    chk("rst_con_rx_stb", 32'(o_con_rx_stb), 0);
    chk("rst_hb_rx_stb", 32'(o_hb_rx_stb), 0);
    chk("rst_con_rx_data", 32'(o_con_rx_data), 0);
    chk("rst_hb_rx_data", 32'(o_hb_rx_data), 0);
    chk("rst_hb_busy", 32'(o_hb_tx_busy), 1);
    chk("rst_con_busy", 32'(o_con_tx_busy), 1);
    drive_sources();
    i_reset_n = 1'b1;

    // Rx demux by tag bit
    step(1'b1, 8'h41);
    chk("rx1_con_stb", 32'(o_con_rx_stb), 1);
    chk("rx1_con_data", 32'(o_con_rx_data), 32'h41);
    chk("rx1_hb_stb", 32'(o_hb_rx_stb), 0);
    step(1'b1, 8'hC1);
    chk("rx2_hb_stb", 32'(o_hb_rx_stb), 1);
    chk("rx2_hb_data", 32'(o_hb_rx_data), 32'h41);
    chk("rx2_con_stb", 32'(o_con_rx_stb), 0);
    step(1'b0, 8'h00);

    // Hexbus packet "R1\n" holds off a pending console 'x'
    sent_q.delete();
    hb_q.push_back(7'h52); hb_q.push_back(7'h31); hb_q.push_back(7'h0a);
    con_q.push_back(7'h78);
    step(1'b0, 8'h00);
    chk("pkt_con_busy1", 32'(o_con_tx_busy), 1);
    step(1'b0, 8'h00);
    chk("pkt_con_busy2", 32'(o_con_tx_busy), 1);
    repeat (3) step(1'b0, 8'h00);
    exp_q.push_back(8'hD2); exp_q.push_back(8'hB1);
    exp_q.push_back(8'h8A); exp_q.push_back(8'h78);
    check_sent("r1_seq");

    // Backpressure: byte held stable, both sources stalled
    con_q.push_back(7'h61);
    step(1'b0, 8'h00);
    i_tx_busy = 1'b1;
    hb_q.push_back(7'h51); hb_q.push_back(7'h0a);
    con_q.push_back(7'h62);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00);
      chk("hold_stb", 32'(o_tx_stb), 1);
      chk("hold_byte", 32'(o_tx_byte), 32'h61);
      chk("hold_hb_busy", 32'(o_hb_tx_busy), 1);
      chk("hold_con_busy", 32'(o_con_tx_busy), 1);
    end
    i_tx_busy = 1'b0;
    repeat (5) step(1'b0, 8'h00);
    exp_q.push_back(8'h61); exp_q.push_back(8'hD1);
    exp_q.push_back(8'h8A); exp_q.push_back(8'h62);
    check_sent("hold_seq");

    // Idle timeout of an unterminated packet
    hb_q.push_back(7'h41);
    step(1'b0, 8'h00);
    con_q.push_back(7'h7A);
    for (int k = 1; k <= (1 << LG); k++) begin
      step(1'b0, 8'h00);
      chk("to_wait_stb", 32'(o_tx_stb), 0);
    end
    step(1'b0, 8'h00);
    chk("to_con_stb", 32'(o_tx_stb), 1);
    chk("to_con_byte", 32'(o_tx_byte), 32'h7A);
    sent_q.delete();

    // Fairness: console wins after a hexbus packet, hexbus after a console char
    hb_q.push_back(7'h0a);
    step(1'b0, 8'h00);
    hb_q.push_back(7'h48); hb_q.push_back(7'h0a);
    con_q.push_back(7'h63); con_q.push_back(7'h64);
    repeat (5) step(1'b0, 8'h00);
    exp_q.push_back(8'h8A); exp_q.push_back(8'h63); exp_q.push_back(8'hC8);
    exp_q.push_back(8'h8A); exp_q.push_back(8'h64);
    check_sent("fair_seq");

    // Asynchronous reset while the transmitter is stalled
    i_tx_busy = 1'b1;
    con_q.push_back(7'h65);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("pre_rst_stb", 32'(o_tx_stb), 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_tx_stb", 32'(o_tx_stb), 0);
    chk("arst_hb_busy", 32'(o_hb_tx_busy), 1);
    chk("arst_con_busy", 32'(o_con_tx_busy), 1);
    model_reset();
    hb_q.delete(); con_q.delete(); sent_q.delete();
    drive_sources();
    i_tx_busy = 1'b0;
    @(posedge i_clk);
    #1;
    chk("arst_held_stb", 32'(o_tx_stb), 0);
    i_reset_n = 1'b1;
    hb_q.push_back(7'h4B); hb_q.push_back(7'h0a);
    step(1'b0, 8'h00);
    chk("post_rst_byte", 32'(o_tx_byte), 32'hCB);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    exp_q.push_back(8'hCB); exp_q.push_back(8'h8A);
    check_sent("post_rst_seq");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      i_tx_busy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0 && hb_q.size() < 4)
        hb_q.push_back(($urandom_range(0, 3) == 0) ? 7'h0a : 7'($urandom));
      if ($urandom_range(0, 3) == 0 && con_q.size() < 4)
        con_q.push_back(7'($urandom));
      step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    sent_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hbconsole_link.md
HBCONSOLE_LINK -- requirements
Module: hbconsole_link

Interface
REQ-001 SHALL have parameter LGIDLE, default 10, log2 of the HB_PKT idle-timeout in clocks.
REQ-002 SHALL have port i_clk, input, 1: sole clock, all logic on rising edge.
REQ-003 SHALL have port i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_rx_stb, input, 1: UART receiver byte valid, single-cycle.
REQ-005 SHALL have port i_rx_byte, input, 8: UART received byte.
REQ-006 SHALL have port o_con_rx_stb, output, 1: console receive char valid.
REQ-007 SHALL have port o_con_rx_data, output, 7: console receive char.
REQ-008 SHALL have port o_hb_rx_stb, output, 1: hexbus command char valid.
REQ-009 SHALL have port o_hb_rx_data, output, 7: hexbus command char.
REQ-010 SHALL have port i_con_tx_stb, input, 1: console transmit char request.
REQ-011 SHALL have port i_con_tx_data, input, 7: console transmit char.
REQ-012 SHALL have port o_con_tx_busy, output, 1: console char not accepted this cycle.
REQ-013 SHALL have port i_hb_tx_stb, input, 1: hexbus response char request.
REQ-014 SHALL have port i_hb_tx_data, input, 7: hexbus response char.
REQ-015 SHALL have port o_hb_tx_busy, output, 1: hexbus char not accepted this cycle.
REQ-016 SHALL have port o_tx_stb, output, 1: byte valid to UART transmitter.
REQ-017 SHALL have port o_tx_byte, output, 8: byte to UART transmitter.
REQ-018 SHALL have port i_tx_busy, input, 1: UART transmitter cannot take a byte.

Function
REQ-019 Rx demux SHALL be registered, 1-clock latency: i_rx_byte[7]=0 -> o_con_rx_stb; [7]=1 -> o_hb_rx_stb; data = i_rx_byte[6:0]. Never both strobes in one cycle.
REQ-020 load = !o_tx_stb || !i_tx_busy. A source is accepted iff load && selected && its stb. Its busy = !(load && selected).
REQ-021 On accept, o_tx_stb<=1 and o_tx_byte<={tag,data} next clock: tag 1 = hexbus, 0 = console. No accept && !i_tx_busy: o_tx_stb<=0.
REQ-022 While o_tx_stb && i_tx_busy, o_tx_stb and o_tx_byte SHALL stay stable.
REQ-023 FSM states IDLE, HB_PKT. IDLE: select hexbus if i_hb_tx_stb && !(last_hb && i_con_tx_stb), else select console.
REQ-024 IDLE, hexbus char accepted and != 7'h0a: -> HB_PKT. Newline-only packet stays IDLE and sets last_hb.
REQ-025 HB_PKT: only hexbus selectable; console always busy. Hexbus 7'h0a accepted -> IDLE, last_hb<=1.
REQ-026 Accepting a console char SHALL clear last_hb.
REQ-027 HB_PKT idle counter (LGIDLE bits): increments each cycle with !i_hb_tx_stb, clears on i_hb_tx_stb. At all-ones -> IDLE, last_hb<=1, counter<=0.
REQ-028 Counter SHALL saturate/clear, never wrap while in HB_PKT. Held at 0 in IDLE.
REQ-029 Rx and tx paths are independent: simultaneous rx byte and tx accept both proceed.

Reset
REQ-030 i_reset_n low, asynchronously: o_tx_stb, o_con_rx_stb, o_hb_rx_stb = 0; o_tx_byte, rx data = 0; state IDLE; last_hb 0; counter 0.
REQ-031 Busy outputs SHALL be 1 during reset. Reset mid-byte SHALL drop o_tx_stb with no retry.
REQ-032 Reset deassertion has no sync requirement on this block; first accept possible on the first clock after release.

Structure
REQ-033 Newline constant 7'h0a, state encodings and tag bit position SHALL live in shared header hbconsole_defs.
REQ-034 Single flat module, no sub-modules.

Verification
REQ-035 Rx 0x41 then 0xC1 -> o_con_rx_stb with 0x41 next clock, then o_hb_rx_stb with 0x41; never overlapping.
REQ-036 Hexbus "R1\n" with console 'x' pending from start -> tx bytes 0xD2,0xB1,0x8A then 0x78; o_con_tx_busy=1 throughout HB_PKT.
REQ-037 i_tx_busy=1 for 5 clocks with o_tx_stb=1 -> o_tx_byte unchanged, both source busies=1.
REQ-038 HB_PKT after 'A', no hexbus stb for 2^LGIDLE clocks -> returns IDLE; pending console char sent next.
REQ-039 Both sources requesting, last_hb=1 -> console first. Then last_hb=0 -> hexbus first.
REQ-040 i_reset_n pulsed low mid-transfer with i_tx_busy=1 -> o_tx_stb=0 immediately, state IDLE, next hexbus char accepted normally.
